// File: rtl/cla_pkg.sv
// Shared constants and types for the 8-bit carry-lookahead adder/subtractor.
package cla_pkg;
  localparam int CLA_W    = 8;
  localparam int CLA_GRP  = 4;
  localparam int CLA_NGRP = CLA_W / CLA_GRP;
  typedef logic [CLA_W-1:0] word_t;
endpackage

// File: rtl/cla_addsub_8bit_if.sv
// Operand/result bundle for cla_addsub_8bit; slave is the arithmetic unit side.
interface cla_addsub_8bit_if;
  import cla_pkg::*;
  word_t A;
  word_t B;
  logic  Add_ctrl;
  word_t SUM;
  logic  C_out;
  logic  v;

  modport master (output A, B, Add_ctrl, input SUM, C_out, v);
  modport slave  (input A, B, Add_ctrl, output SUM, C_out, v);
endinterface

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead slice: fully expanded internal carries plus group generate/propagate.
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c3,
  output logic       cout,
  output logic       gg,
  output logic       gp
);
  logic [3:0] g, p;
  logic       c1, c2;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum-of-products of g/p/cin, so no carry ripples through c1/c2.
  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;
  assign cout = gg | (gp & cin);

  assign s = p ^ {c3, c2, c1, cin};
endmodule

// File: rtl/cla_addsub_8bit.sv
// Registered 8-bit two's-complement add/subtract built from two 4-bit lookahead slices.
module cla_addsub_8bit
  import cla_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  cla_addsub_8bit_if.slave     bus
);
  word_t               bx;
  logic                c0, c4, c8;
  logic [CLA_NGRP-1:0] gg, gp, grp_cin, grp_cout, grp_c3;
  word_t               sum_d, sum_q;
  logic                cout_d, cout_q, v_d, v_q;

  // Subtract is A + ~B + 1: invert B and inject the +1 as carry-in.
  assign bx = bus.Add_ctrl ? bus.B : ~bus.B;
  assign c0 = ~bus.Add_ctrl;

  assign c4 = gg[0] | (gp[0] & c0);
  assign c8 = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c0);
  assign grp_cin = {c4, c0};

  for (genvar gi = 0; gi < CLA_NGRP; gi++) begin : g_grp
    cla_4bit u_grp (
      .a    (bus.A[gi*CLA_GRP +: CLA_GRP]),
      .b    (bx[gi*CLA_GRP +: CLA_GRP]),
      .cin  (grp_cin[gi]),
      .s    (sum_d[gi*CLA_GRP +: CLA_GRP]),
      .c3   (grp_c3[gi]),
      .cout (grp_cout[gi]),
      .gg   (gg[gi]),
      .gp   (gp[gi])
    );
  end

  // Slice carry-outs duplicate c4/c8 from the group lookahead; only the top c3 feeds overflow.
  logic unused_grp;
  assign unused_grp = ^{grp_cout, grp_c3[0]};

  assign cout_d = c8;
  assign v_d    = c8 ^ grp_c3[CLA_NGRP-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      v_q    <= v_d;
    end
  end

  assign bus.SUM   = sum_q;
  assign bus.C_out = cout_q;
  assign bus.v     = v_q;
endmodule

// File: tb/tb_cla_addsub_8bit.sv
// Bench for cla_addsub_8bit: directed vector table, reset/hold sequences, strided and random sweeps.
module tb_cla_addsub_8bit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cla_addsub_8bit_if bus ();
  cla_addsub_8bit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       add;
    logic [7:0] sum;
    logic       cout;
    logic       v;
  } vec_t;

  vec_t        vecs[12];
  logic [9:0]  exp_q[$];

  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic add);
    logic [8:0] r;
    logic       ov;
    if (add) r = {1'b0, a} + {1'b0, b};
    else     r = {1'b0, a} + {1'b0, ~b} + 9'd1;
    if (add) ov = (a[7] == b[7]) && (r[7] != a[7]);
    else     ov = (a[7] != b[7]) && (r[7] != a[7]);
    return {r[7:0], r[8], ov};
  endfunction

  task automatic check(input string name, input logic [9:0] exp);
    logic [9:0] got;
    got = {bus.SUM, bus.C_out, bus.v};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got SUM=%h C_out=%b v=%b, expected SUM=%h C_out=%b v=%b (A=%h B=%h add=%b)",
               name, got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0], bus.A, bus.B, bus.Add_ctrl);
    end
  endtask

  // Drive between edges, push expectation, compare #1 after the sampling edge.
  task automatic apply(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic add, input logic [9:0] exp);
    bus.A = a; bus.B = b; bus.Add_ctrl = add;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      check(name, exp_q.pop_front());
    end
  endtask

  initial begin
    vecs[0]  = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{8'h02, 8'h03, 1'b1, 8'h05, 1'b0, 1'b0};
    vecs[3]  = '{8'h02, 8'h03, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[4]  = '{8'h7F, 8'h7F, 1'b1, 8'hFE, 1'b0, 1'b1};
    vecs[5]  = '{8'h7F, 8'h7F, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[7]  = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b1, 1'b1};
    vecs[8]  = '{8'h81, 8'h7F, 1'b0, 8'h02, 1'b1, 1'b1};
    vecs[9]  = '{8'hFE, 8'hFD, 1'b1, 8'hFB, 1'b1, 1'b0};
    vecs[10] = '{8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[11] = '{8'h0F, 8'h01, 1'b1, 8'h10, 1'b0, 1'b0};

    bus.A = 8'hA5; bus.B = 8'h5A; bus.Add_ctrl = 1'b1;
    #1;
    check("reset_state", 10'h000);
    @(posedge clk); #1;
    check("reset_held_over_edge", 10'h000);
    #2 rst_n = 1'b1;

    foreach (vecs[i])
      apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].add,
            {vecs[i].sum, vecs[i].cout, vecs[i].v});

    // Inputs moving between edges must not disturb the registered result.
    apply("hold_pre", 8'h05, 8'h03, 1'b1, {8'h08, 1'b0, 1'b0});
    #2 bus.A = 8'h7F; bus.B = 8'h80; bus.Add_ctrl = 1'b0;
    #1 check("hold_between_edges", {8'h08, 1'b0, 1'b0});

    // Async reset mid-cycle clears at once; in-flight result is dropped.
    @(posedge clk); #1;
    check("pre_reset_nonzero", model(8'h7F, 8'h80, 1'b0));
    #2 rst_n = 1'b0;
    #1 check("reset_async_clear", 10'h000);
    bus.A = 8'h10; bus.B = 8'h20; bus.Add_ctrl = 1'b1;
    @(posedge clk); #1;
    check("reset_discard_inflight", 10'h000);
    #2 rst_n = 1'b1;
    bus.A = 8'h40; bus.B = 8'h41; bus.Add_ctrl = 1'b0;
    #1 check("reset_release_no_edge", 10'h000);
    @(posedge clk); #1;
    check("reset_first_edge_loads", {8'hFF, 1'b0, 1'b0});

    // Strided sweep: every A against 16 B values, both modes.
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 256; b += 17)
        for (int m = 0; m < 2; m++)
          apply("sweep", 8'(a), 8'(b), 1'(m), model(8'(a), 8'(b), 1'(m)));

    for (int n = 0; n < 2000; n++) begin
      logic [7:0] ra, rb;
      logic       rm;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rm = 1'($urandom_range(0, 1));
      apply("random", ra, rb, rm, model(ra, rb, rm));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
